// File: rtl/seq_divider.sv
// seq_divider: multi-cycle radix-2 restoring integer divider.
// It produces one quotient bit per clock. Every operation takes the same
// number of cycles, including divide-by-zero.
//
// Ports:
//   clk, reset_n            rising-edge clock, async active-low reset
//   start                   request, sampled only while busy=0
//   signed_mode             1 = two's-complement operands (sampled with start)
//   dividend, divisor       operands (sampled with start)
//   busy                    operation in progress
//   done                    one-cycle pulse when results are updated
//   quotient, remainder     registered results, held between operations
//   div_by_zero             latched divisor was zero (held with results)
module seq_divider #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  typedef enum logic [1:0] {IDLE, CALC, FIXUP} state_t;

  state_t           state;
  logic [WIDTH:0]   rem;      // partial remainder, one guard bit
  logic [WIDTH-1:0] q;        // holds the dividend magnitude first, then the quotient shifts in
  logic [WIDTH-1:0] dsr_mag;
  logic [WIDTH-1:0] dvd_raw;  // raw dividend, returned as the remainder on divide-by-zero
  logic [CNT_W-1:0] cnt;
  logic             neg_q, neg_r, dz;

  // operand magnitudes at the accept cycle
  logic             dvd_neg, dsr_neg;
  logic [WIDTH-1:0] dvd_mag_in, dsr_mag_in;
  assign dvd_neg    = signed_mode & dividend[WIDTH-1];
  assign dsr_neg    = signed_mode & divisor[WIDTH-1];
  assign dvd_mag_in = dvd_neg ? -dividend : dividend;
  assign dsr_mag_in = dsr_neg ? -divisor  : divisor;

  // One restoring step. The extra top bit of trial is its sign, so the
  // compare stays safe even when rem has drifted wide (dz case).
  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] trial;
  assign shifted = {rem[WIDTH-1:0], q[WIDTH-1]};
  assign trial   = {1'b0, shifted} - {2'b00, dsr_mag};

  // Sign correction of the magnitudes. MIN/-1 wraps to MIN naturally.
  logic [WIDTH-1:0] q_fix, r_fix;
  assign q_fix = neg_q ? -q : q;
  assign r_fix = neg_r ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      rem         <= '0;
      q           <= '0;
      dsr_mag     <= '0;
      dvd_raw     <= '0;
      cnt         <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      dz          <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            q       <= dvd_mag_in;
            dsr_mag <= dsr_mag_in;
            dvd_raw <= dividend;
            neg_q   <= dvd_neg ^ dsr_neg;
            neg_r   <= dvd_neg;
            dz      <= (divisor == '0);
            rem     <= '0;
            cnt     <= CNT_W'(WIDTH);
            busy    <= 1'b1;
            state   <= CALC;
          end
        end
        CALC: begin
          if (!trial[WIDTH+1]) begin
            rem <= trial[WIDTH:0];
            q   <= {q[WIDTH-2:0], 1'b1};
          end else begin
            rem <= shifted;
            q   <= {q[WIDTH-2:0], 1'b0};
          end
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) state <= FIXUP;
        end
        FIXUP: begin
          if (dz) begin
            quotient  <= '1;
            remainder <= dvd_raw;
          end else begin
            quotient  <= q_fix;
            remainder <= r_fix;
          end
          div_by_zero <= dz;
          done        <= 1'b1;
          busy        <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider. WIDTH=32 directed table and handshake sequences,
// plus a WIDTH=8 instance driven with random operands against an
// integer-arithmetic reference.
module tb_seq_divider;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic        s32, sm32, busy32, done32, dz32;
  logic [31:0] a32, b32, q32, r32;
  logic        s8, sm8, busy8, done8, dz8;
  logic [7:0]  a8, b8, q8, r8;

  int checks = 0;
  int failures = 0;

  seq_divider #(.WIDTH(32)) u32 (
    .clk(clk), .reset_n(reset_n), .start(s32), .signed_mode(sm32),
    .dividend(a32), .divisor(b32), .busy(busy32), .done(done32),
    .quotient(q32), .remainder(r32), .div_by_zero(dz32));

  seq_divider #(.WIDTH(8)) u8 (
    .clk(clk), .reset_n(reset_n), .start(s8), .signed_mode(sm8),
    .dividend(a8), .divisor(b8), .busy(busy8), .done(done8),
    .quotient(q8), .remainder(r8), .div_by_zero(dz8));

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Starts an operation at #1 after an edge and returns at #1 after the
  // edge that raised done (or after a bounded wait).
  task automatic op32(input logic sm, input logic [31:0] a, input logic [31:0] b,
                      output logic [31:0] q, output logic [31:0] r,
                      output logic dz, output int lat);
    s32 = 1'b1; sm32 = sm; a32 = a; b32 = b; lat = 0;
    do begin
      @(posedge clk); #1; lat++;
      if (lat == 1) begin
        s32 = 1'b0;
        chk("busy_after_start32", busy32, 1);
      end
    end while (!done32 && lat < 100);
    chk("done_seen32", done32, 1);
    chk("busy_low_at_done32", busy32, 0);
    q = q32; r = r32; dz = dz32;
  endtask

  task automatic op8(input logic sm, input logic [7:0] a, input logic [7:0] b,
                     output logic [7:0] q, output logic [7:0] r,
                     output logic dz, output int lat);
    s8 = 1'b1; sm8 = sm; a8 = a; b8 = b; lat = 0;
    do begin
      @(posedge clk); #1; lat++;
      if (lat == 1) s8 = 1'b0;
    end while (!done8 && lat < 100);
    chk("done_seen8", done8, 1);
    q = q8; r = r8; dz = dz8;
  endtask

  // Reference: plain integer division (truncating, remainder follows dividend).
  function automatic void ref8(input logic sm, input logic [7:0] a, input logic [7:0] b,
                               output logic [7:0] q, output logic [7:0] r, output logic dz);
    int sa, sb, qi, ri;
    dz = (b == 8'd0);
    q = 8'hFF; r = a;
    if (dz) return;
    if (sm) begin sa = $signed(a); sb = $signed(b); end
    else    begin sa = a;          sb = b;          end
    qi = sa / sb;
    ri = sa % sb;
    q = qi[7:0];
    r = ri[7:0];
  endfunction

  function automatic logic [7:0] pick8();
    logic [7:0] sp[5];
    sp = '{8'h00, 8'h01, 8'hFF, 8'h80, 8'h7F};
    if ($urandom_range(0, 3) == 0) return sp[$urandom_range(0, 4)];
    return 8'($urandom);
  endfunction

  typedef struct {
    logic        sm;
    logic [31:0] a, b, q, r;
    logic        dz;
  } vec_t;

  vec_t tbl[12];

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] gq, gr;
    logic [7:0]  g8q, g8r, e8q, e8r;
    logic        gdz, e8dz;
    int lat, nd;

    s32 = 0; sm32 = 0; a32 = 0; b32 = 0;
    s8 = 0;  sm8 = 0;  a8 = 0;  b8 = 0;

    // --- reset state ---
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy32, 0);
    chk("rst_done", done32, 0);
    chk("rst_q", q32, 0);
    chk("rst_r", r32, 0);
    chk("rst_dz", dz32, 0);
    chk("rst_q8", q8, 0);
    chk("rst_busy8", busy8, 0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // --- directed WIDTH=32 table ---
    tbl[0]  = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0};
    tbl[1]  = '{1'b1, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF,   1'b0};
    tbl[2]  = '{1'b1, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   32'd1,          1'b0};
    tbl[3]  = '{1'b1, 32'hFFFFFFF9,   32'hFFFFFFFE,   32'd3,          32'hFFFFFFFF,   1'b0};
    tbl[4]  = '{1'b0, 32'hFFFFFFF9,   32'd2,          32'h7FFFFFFC,   32'd1,          1'b0};
    tbl[5]  = '{1'b0, 32'h12345678,   32'd0,          32'hFFFFFFFF,   32'h12345678,   1'b1};
    tbl[6]  = '{1'b0, 32'd5,          32'd9,          32'd0,          32'd5,          1'b0};
    tbl[7]  = '{1'b1, 32'h12345678,   32'd0,          32'hFFFFFFFF,   32'h12345678,   1'b1};
    tbl[8]  = '{1'b1, 32'hFFFFFFF9,   32'd0,          32'hFFFFFFFF,   32'hFFFFFFF9,   1'b1};
    tbl[9]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          1'b0};
    tbl[10] = '{1'b1, 32'd5,          32'd9,          32'd0,          32'd5,          1'b0};
    tbl[11] = '{1'b0, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   32'd0,          1'b0};

    foreach (tbl[i]) begin
      op32(tbl[i].sm, tbl[i].a, tbl[i].b, gq, gr, gdz, lat);
      chk($sformatf("tbl%0d_q", i),   gq,  tbl[i].q);
      chk($sformatf("tbl%0d_r", i),   gr,  tbl[i].r);
      chk($sformatf("tbl%0d_dz", i),  gdz, tbl[i].dz);
      chk($sformatf("tbl%0d_lat", i), lat, 34);
    end

    // --- reset in the middle of CALC ---
    s32 = 1'b1; sm32 = 1'b0; a32 = 32'd100; b32 = 32'd7;
    @(posedge clk); #1; s32 = 1'b0;
    repeat (10) @(posedge clk);
    #1; reset_n = 1'b0;
    #1;
    chk("midrst_busy", busy32, 0);
    chk("midrst_done", done32, 0);
    chk("midrst_q", q32, 0);
    chk("midrst_r", r32, 0);
    chk("midrst_dz", dz32, 0);
    repeat (2) @(posedge clk);
    #1; reset_n = 1'b1;
    nd = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done32) nd++;
    end
    chk("midrst_no_done", nd, 0);
    op32(1'b0, 32'd100, 32'd7, gq, gr, gdz, lat);
    chk("midrst_q_after", gq, 14);
    chk("midrst_r_after", gr, 2);
    chk("midrst_lat_after", lat, 34);

    // --- start held high for 40 cycles; operands switched while busy ---
    s32 = 1'b1; sm32 = 1'b0; a32 = 32'd100; b32 = 32'd7; nd = 0;
    for (int c = 1; c <= 80; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin sm32 = 1'b1; a32 = 32'hFFFFFFF9; b32 = 32'd2; end
      if (c == 40) s32 = 1'b0;
      if (c == 35) chk("hold_busy_second", busy32, 1);
      if (done32) begin
        nd++;
        if (nd == 1) begin
          chk("hold_first_at", c, 34);
          chk("hold_first_q", q32, 14);
          chk("hold_first_r", r32, 2);
        end else if (nd == 2) begin
          chk("hold_second_at", c, 68);
          chk("hold_second_q", q32, 32'hFFFFFFFD);
          chk("hold_second_r", r32, 32'hFFFFFFFF);
        end
      end
    end
    chk("hold_done_count", nd, 2);

    // --- start pulsed while busy with other operands: ignored ---
    s32 = 1'b1; sm32 = 1'b0; a32 = 32'd1000; b32 = 32'd3; nd = 0;
    for (int c = 1; c <= 50; c++) begin
      @(posedge clk); #1;
      if (c == 1) s32 = 1'b0;
      if (c == 5) begin s32 = 1'b1; a32 = 32'd9; b32 = 32'd9; end
      if (c == 6) s32 = 1'b0;
      if (done32) begin
        nd++;
        chk("pulse_done_at", c, 34);
        chk("pulse_q", q32, 333);
        chk("pulse_r", r32, 1);
      end
    end
    chk("pulse_done_count", nd, 1);
    repeat (5) @(posedge clk);
    #1;
    chk("idle_hold_q", q32, 333);
    chk("idle_hold_r", r32, 1);
    chk("idle_done_low", done32, 0);

    // --- WIDTH=8 random vs reference ---
    for (int i = 0; i < 1000; i++) begin
      logic sm;
      logic [7:0] a, b;
      sm = 1'($urandom);
      a = pick8();
      b = pick8();
      ref8(sm, a, b, e8q, e8r, e8dz);
      op8(sm, a, b, g8q, g8r, gdz, lat);
      if (g8q !== e8q || g8r !== e8r || gdz !== e8dz)
        $display("  operands sm=%0d a=%0h b=%0h", sm, a, b);
      chk("rnd8_q", g8q, e8q);
      chk("rnd8_r", g8r, e8r);
      chk("rnd8_dz", gdz, e8dz);
      chk("rnd8_lat", lat, 10);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
